// File: rtl/rank_filter_pkg.sv
// Shared types and helpers for the rank-order filter pipeline.
package rank_filter_pkg;

   localparam int unsigned MAX_DATA_W = 16;

   typedef enum logic [1:0] {
      MODE_MEDIAN   = 2'd0,
      MODE_MIN      = 2'd1,
      MODE_MAX      = 2'd2,
      MODE_ADAPTIVE = 2'd3
   } filt_mode_e;

   // Side-band fields travelling with each window; data and centre are sized by the instantiator.
   typedef struct packed {
      logic       valid;
      filt_mode_e mode;
      logic       last;
   } stage_ctrl_t;

   // True when the low 'width' bits of pixel are all zeros or all ones.
   function automatic logic is_impulse(input logic [MAX_DATA_W-1:0] pixel,
                                       input int unsigned width);
      logic [MAX_DATA_W-1:0] full;
      full = '0;
      for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
         if (i < width) full[i] = 1'b1;
      end
      return (pixel == '0) || (pixel == full);
   endfunction

endpackage

// File: rtl/oe_sort_stage.sv
// One registered compare-exchange pass of an odd-even transposition sorter.
module oe_sort_stage
   import rank_filter_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned N_TAPS    = 9,
   parameter bit          ODD_PHASE = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  stage_ctrl_t              up_ctrl,
   input  logic [N_TAPS*DATA_W-1:0] up_data,
   input  logic [DATA_W-1:0]        up_centre,
   output stage_ctrl_t              ctrl,
   output logic [N_TAPS*DATA_W-1:0] data,
   output logic [DATA_W-1:0]        centre
);

   localparam int unsigned VEC_W = N_TAPS * DATA_W;
   // Odd passes pair (0,1),(2,3)...; even passes pair (1,2),(3,4)...
   localparam int unsigned FIRST = ODD_PHASE ? 32'd0 : 32'd1;

   logic [VEC_W-1:0] swapped_c;

   // Smaller value to the lower index; ties stay put.
   always_comb begin
      swapped_c = up_data;
      for (int unsigned i = FIRST; i + 1 < N_TAPS; i += 2) begin
         if (up_data[(i+1)*DATA_W +: DATA_W] < up_data[i*DATA_W +: DATA_W]) begin
            swapped_c[i*DATA_W +: DATA_W]     = up_data[(i+1)*DATA_W +: DATA_W];
            swapped_c[(i+1)*DATA_W +: DATA_W] = up_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ctrl   <= '0;
         data   <= '0;
         centre <= '0;
      end else if (en) begin
         ctrl   <= up_ctrl;
         data   <= swapped_c;
         centre <= up_centre;
      end
   end

endmodule

// File: rtl/rank_order_filter.sv
// Pipelined rank-order filter: capture, N_TAPS sort passes, registered output select.
module rank_order_filter
   import rank_filter_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned N_TAPS = 9
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N_TAPS*DATA_W-1:0] in_px,
   input  logic [1:0]               in_mode,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_px,
   output logic                     out_last
);

   localparam int unsigned VEC_W  = N_TAPS * DATA_W;
   localparam int unsigned CENTRE = N_TAPS / 2;

   if ((N_TAPS % 2) == 0 || N_TAPS < 3 || N_TAPS > 25 ||
       DATA_W < 4 || DATA_W > MAX_DATA_W) begin : g_bad_param
      $error("rank_order_filter: N_TAPS must be odd in 3..25 and DATA_W in 4..16");
   end

   stage_ctrl_t [N_TAPS:0]              st_ctrl;
   logic        [N_TAPS:0][VEC_W-1:0]   st_data;
   logic        [N_TAPS:0][DATA_W-1:0]  st_centre;

   logic              adv;
   logic [DATA_W-1:0] med_c;
   logic [DATA_W-1:0] sel_c;

   // Global stall: every register advances together or holds together.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   stage_ctrl_t             cap_ctrl;
   logic [VEC_W-1:0]        cap_data;
   logic [DATA_W-1:0]       cap_centre;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cap_ctrl   <= '0;
         cap_data   <= '0;
         cap_centre <= '0;
      end else if (adv) begin
         cap_ctrl.valid <= in_valid;
         cap_ctrl.mode  <= filt_mode_e'(in_mode);
         cap_ctrl.last  <= in_last;
         cap_data       <= in_px;
         cap_centre     <= in_px[CENTRE*DATA_W +: DATA_W];
      end
   end

   assign st_ctrl[0]   = cap_ctrl;
   assign st_data[0]   = cap_data;
   assign st_centre[0] = cap_centre;

   for (genvar k = 1; k <= int'(N_TAPS); k++) begin : g_stage
      oe_sort_stage #(
         .DATA_W    (DATA_W),
         .N_TAPS    (N_TAPS),
         .ODD_PHASE (bit'(k % 2))
      ) u_pass (
         .clk       (clk),
         .rst       (rst),
         .en        (adv),
         .up_ctrl   (st_ctrl[k-1]),
         .up_data   (st_data[k-1]),
         .up_centre (st_centre[k-1]),
         .ctrl      (st_ctrl[k]),
         .data      (st_data[k]),
         .centre    (st_centre[k])
      );
   end

   // Rank select from the fully sorted window.
   always_comb begin
      med_c = st_data[N_TAPS][CENTRE*DATA_W +: DATA_W];
      sel_c = med_c;
      case (st_ctrl[N_TAPS].mode)
         MODE_MIN:      sel_c = st_data[N_TAPS][0 +: DATA_W];
         MODE_MAX:      sel_c = st_data[N_TAPS][(N_TAPS-1)*DATA_W +: DATA_W];
         MODE_ADAPTIVE: sel_c = is_impulse(MAX_DATA_W'(st_centre[N_TAPS]), DATA_W) ?
                                med_c : st_centre[N_TAPS];
         default:       sel_c = med_c;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_px    <= '0;
         out_last  <= 1'b0;
      end else if (adv) begin
         out_valid <= st_ctrl[N_TAPS].valid;
         if (st_ctrl[N_TAPS].valid) begin
            out_px   <= sel_c;
            out_last <= st_ctrl[N_TAPS].last;
         end
      end
   end

endmodule

// File: tb/tb_rank_order_filter.sv
// Bench for rank_order_filter: directed table, random stream with stall, reset flush, 25-tap config.
module tb_rank_order_filter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 9-tap, 8-bit instance
   logic         a_rst, a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_last;
   logic [71:0]  a_in_px;
   logic [1:0]   a_in_mode;
   logic [7:0]   a_out_px;

   // 25-tap, 10-bit instance
   logic         b_rst, b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_last;
   logic [249:0] b_in_px;
   logic [1:0]   b_in_mode;
   logic [9:0]   b_out_px;

   rank_order_filter #(.DATA_W(8), .N_TAPS(9)) u_a (
      .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_px(a_in_px), .in_mode(a_in_mode), .in_last(a_in_last),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_px(a_out_px), .out_last(a_out_last));

   rank_order_filter #(.DATA_W(10), .N_TAPS(25)) u_b (
      .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_px(b_in_px), .in_mode(b_in_mode), .in_last(b_in_last),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_px(b_out_px), .out_last(b_out_last));

   typedef struct {
      int   px;
      logic last;
      int   acc;
      bit   lat;
   } exp_t;

   typedef struct packed {
      logic [71:0] px;
      logic [1:0]  mode;
      logic [7:0]  exp;
   } vec_t;

   exp_t a_q[$];
   exp_t b_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   a_cyc = 0;
   int   b_cyc = 0;
   bit   a_hold = 0;
   logic [7:0] a_hold_px;
   logic       a_hold_last;

   task automatic chk(input bit ok, input string name, input int act, input int req);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   // k-th smallest (0-based) by counting ranks, duplicates included.
   function automatic int kth(input int w[25], input int n, input int r);
      for (int i = 0; i < n; i++) begin
         int lt = 0;
         int le = 0;
         for (int j = 0; j < n; j++) begin
            if (w[j] < w[i]) lt++;
            if (w[j] <= w[i]) le++;
         end
         if (lt <= r && r < le) return w[i];
      end
      return -1;
   endfunction

   function automatic int ref_out(input int w[25], input int n, input int dw, input int mode);
      int med = kth(w, n, n / 2);
      int c = w[n / 2];
      int full = (1 << dw) - 1;
      case (mode)
         1:       return kth(w, n, 0);
         2:       return kth(w, n, n - 1);
         3:       return (c == 0 || c == full) ? med : c;
         default: return med;
      endcase
   endfunction

   function automatic logic [399:0] packw(input int w[25], input int n, input int dw);
      logic [399:0] v = '0;
      for (int i = 0; i < n; i++)
         for (int b = 0; b < dw; b++)
            v[i*dw + b] = w[i][b];
      return v;
   endfunction

   function automatic logic [71:0] win9(input int p0, input int p1, input int p2, input int p3,
                                        input int p4, input int p5, input int p6, input int p7,
                                        input int p8);
      int w[25];
      foreach (w[i]) w[i] = 0;
      w[0] = p0; w[1] = p1; w[2] = p2; w[3] = p3; w[4] = p4;
      w[5] = p5; w[6] = p6; w[7] = p7; w[8] = p8;
      return 72'(packw(w, 9, 8));
   endfunction

   // One clock of instance A, called at a negedge; scoreboards the handshake at the next posedge.
   task automatic a_step(input logic v, input logic [71:0] px, input logic [1:0] mode,
                         input logic last, input logic rdy, input logic rst_v,
                         input int exp_px, input bit lat, output bit acc);
      exp_t e;
      a_in_valid = v; a_in_px = px; a_in_mode = mode; a_in_last = last;
      a_out_ready = rdy; a_rst = rst_v;
      #1;
      if (a_hold) begin
         chk(a_out_valid === 1'b1, "a_stall_valid", int'(a_out_valid), 1);
         chk(a_out_px === a_hold_px, "a_stall_px", int'(a_out_px), int'(a_hold_px));
         chk(a_out_last === a_hold_last, "a_stall_last", int'(a_out_last), int'(a_hold_last));
      end
      a_hold = 0;
      acc = 0;
      if (rst_v) begin
         if (a_out_valid === 1'b1 && rdy) begin
            chk(a_q.size() > 0, "a_unexpected_out", int'(a_out_px), -1);
            if (a_q.size() > 0) begin
               e = a_q.pop_front();
               chk(a_out_px === 8'(e.px), "a_px", int'(a_out_px), e.px);
               chk(a_out_last === e.last, "a_last", int'(a_out_last), int'(e.last));
               if (e.lat) chk(a_cyc - e.acc == 10, "a_latency", a_cyc - e.acc, 10);
            end
         end else if (a_out_valid === 1'b1) begin
            chk(a_in_ready === 1'b0, "a_in_ready_stall", int'(a_in_ready), 0);
            a_hold = 1; a_hold_px = a_out_px; a_hold_last = a_out_last;
         end
         acc = v && (a_in_ready === 1'b1);
         if (acc) a_q.push_back('{exp_px, last, a_cyc + 1, lat});
      end else begin
         a_q.delete();
      end
      @(negedge clk);
      a_cyc++;
   endtask

   task automatic a_drain(input int idle);
      bit acc;
      for (int g = 0; g < 60 && a_q.size() > 0; g++) a_step(0, '0, 0, 0, 1, 1, 0, 0, acc);
      chk(a_q.size() == 0, "a_drain", a_q.size(), 0);
      for (int g = 0; g < idle; g++) a_step(0, '0, 0, 0, 1, 1, 0, 0, acc);
   endtask

   task automatic b_step(input logic v, input logic [249:0] px, input logic last,
                         input logic rst_v, input int exp_px, output bit acc);
      exp_t e;
      b_in_valid = v; b_in_px = px; b_in_mode = 2'd0; b_in_last = last;
      b_out_ready = 1'b1; b_rst = rst_v;
      #1;
      acc = 0;
      if (rst_v) begin
         if (b_out_valid === 1'b1) begin
            chk(b_q.size() > 0, "b_unexpected_out", int'(b_out_px), -1);
            if (b_q.size() > 0) begin
               e = b_q.pop_front();
               chk(b_out_px === 10'(e.px), "b_median", int'(b_out_px), e.px);
               chk(b_out_last === e.last, "b_last", int'(b_out_last), int'(e.last));
               chk(b_cyc - e.acc == 26, "b_latency", b_cyc - e.acc, 26);
            end
         end
         acc = v && (b_in_ready === 1'b1);
         if (acc) b_q.push_back('{exp_px, last, b_cyc + 1, 1'b1});
      end else begin
         b_q.delete();
      end
      @(negedge clk);
      b_cyc++;
   endtask

   function automatic int rnd_px(input int full);
      int r = int'($urandom_range(0, 3));
      if (r == 0) return 0;
      if (r == 1) return full;
      if (r == 2) return int'($urandom_range(0, 3)) + full / 2;
      return int'($urandom_range(0, full));
   endfunction

   initial begin
      vec_t        tbl[10];
      logic [71:0] rw[20];
      logic [1:0]  rm[20];
      int          rexp[20];
      int          w[25];
      bit          acc;
      int          idx, oc, cur;

      a_rst = 0; a_in_valid = 0; a_in_px = '0; a_in_mode = 0; a_in_last = 0; a_out_ready = 1;
      b_rst = 0; b_in_valid = 0; b_in_px = '0; b_in_mode = 0; b_in_last = 0; b_out_ready = 1;
      foreach (w[i]) w[i] = 0;

      tbl[0] = '{win9(9, 3, 7, 1, 5, 8, 2, 6, 4),            2'd0, 8'd5};
      tbl[1] = '{win9(9, 3, 7, 1, 5, 8, 2, 6, 4),            2'd1, 8'd1};
      tbl[2] = '{win9(9, 3, 7, 1, 5, 8, 2, 6, 4),            2'd2, 8'd9};
      tbl[3] = '{win9(200, 200, 200, 200, 200, 200, 200, 200, 200), 2'd0, 8'd200};
      tbl[4] = '{win9(10, 20, 30, 40, 255, 50, 60, 70, 80),  2'd3, 8'd50};
      tbl[5] = '{win9(10, 20, 30, 40, 120, 50, 60, 70, 80),  2'd3, 8'd120};
      tbl[6] = '{win9(10, 20, 30, 40, 0, 50, 60, 70, 80),    2'd3, 8'd40};
      tbl[7] = '{win9(7, 7, 7, 7, 255, 7, 7, 7, 7),          2'd3, 8'd7};
      tbl[8] = '{win9(0, 255, 0, 255, 0, 255, 0, 255, 0),    2'd2, 8'd255};
      tbl[9] = '{win9(255, 254, 253, 252, 251, 250, 249, 248, 247), 2'd1, 8'd247};

      @(negedge clk);
      a_step(0, '0, 0, 0, 1, 0, 0, 0, acc);
      a_step(0, '0, 0, 0, 1, 0, 0, 0, acc);
      chk(a_out_valid === 1'b0, "a_rst_out_valid", int'(a_out_valid), 0);
      chk(a_out_px === 8'd0, "a_rst_out_px", int'(a_out_px), 0);
      chk(a_out_last === 1'b0, "a_rst_out_last", int'(a_out_last), 0);
      a_rst = 1; #1;
      chk(a_in_ready === 1'b1, "a_rst_in_ready", int'(a_in_ready), 1);

      // Directed windows, back-to-back with no backpressure.
      for (int k = 0; k < 10; k++) begin
         a_step(1, tbl[k].px, tbl[k].mode, 1'(k == 9), 1, 1, int'(tbl[k].exp), 1, acc);
         chk(acc, "a_dir_accept", int'(acc), 1);
      end
      a_drain(2);

      // Random stream with a three-cycle output stall.
      for (int i = 0; i < 20; i++) begin
         for (int t = 0; t < 9; t++) w[t] = rnd_px(255);
         rm[i]   = 2'($urandom_range(0, 3));
         rexp[i] = ref_out(w, 9, 8, int'(rm[i]));
         rw[i]   = 72'(packw(w, 9, 8));
      end
      idx = 0; oc = 0;
      for (int g = 0; g < 200 && (idx < 20 || a_q.size() > 0); g++) begin
         if (a_out_valid === 1'b1) oc++;
         cur = (idx < 20) ? idx : 19;
         a_step(1'(idx < 20), rw[cur], rm[cur], 1'(idx == 19), 1'(!(oc >= 5 && oc <= 7)),
                1, rexp[cur], 0, acc);
         if (acc) idx++;
      end
      chk(idx == 20 && a_q.size() == 0, "a_rand_complete", idx, 20);
      a_drain(2);

      // Reset with five windows in flight; a concurrent handshake must lose.
      for (int i = 0; i < 5; i++) begin
         for (int t = 0; t < 9; t++) w[t] = rnd_px(255);
         a_step(1, 72'(packw(w, 9, 8)), 0, 1, 1, 1, ref_out(w, 9, 8, 0), 0, acc);
      end
      a_step(1, tbl[1].px, 2'd1, 1, 1, 0, 1, 0, acc);
      chk(a_out_valid === 1'b0, "a_midrst_out_valid", int'(a_out_valid), 0);
      chk(a_out_px === 8'd0, "a_midrst_out_px", int'(a_out_px), 0);
      chk(a_out_last === 1'b0, "a_midrst_out_last", int'(a_out_last), 0);
      chk(a_in_ready === 1'b1, "a_midrst_in_ready", int'(a_in_ready), 1);
      a_step(1, tbl[0].px, tbl[0].mode, 1, 1, 1, int'(tbl[0].exp), 1, acc);
      chk(acc, "a_post_rst_accept", int'(acc), 1);
      a_drain(15);

      // 25-tap, 10-bit median with duplicates and extremes.
      b_step(0, '0, 0, 0, 0, acc);
      b_step(0, '0, 0, 0, 0, acc);
      chk(b_out_valid === 1'b0, "b_rst_out_valid", int'(b_out_valid), 0);
      chk(b_out_px === 10'd0, "b_rst_out_px", int'(b_out_px), 0);
      for (int i = 0; i < 30; i++) begin
         for (int t = 0; t < 25; t++) w[t] = rnd_px(1023);
         b_step(1, 250'(packw(w, 25, 10)), 1'(i == 29), 1, ref_out(w, 25, 10, 0), acc);
         chk(acc, "b_accept", int'(acc), 1);
      end
      for (int g = 0; g < 60 && b_q.size() > 0; g++) b_step(0, '0, 0, 1, 0, acc);
      chk(b_q.size() == 0, "b_drain", b_q.size(), 0);
      for (int g = 0; g < 5; g++) b_step(0, '0, 0, 1, 0, acc);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rank_order_filter.md
Name: rank_order_filter

Overview:
- Parametrised, fully pipelined rank-order filter for the salt-and-pepper noise path. Successor to the fixed 9-tap median selector.
- Accepts one window of N_TAPS grayscale pixels per cycle under a valid/ready handshake and sorts it with a registered odd-even transposition network.
- Outputs the minimum, median or maximum, or an adaptive result that replaces the centre pixel only when it is an impulse (0 or full-scale).
- Sits between the window/line-buffer generator and the output pixel writer.

Parameters:
- DATA_W, 8: pixel width in bits, 4..16.
- N_TAPS, 9: pixels per window. Must be odd, 3..25. Elaboration-time error otherwise.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-low.
- in_valid  in  1  window on in_px is valid.
- in_ready  out  1  block can accept a window this cycle.
- in_px  in  N_TAPS*DATA_W  window; tap i is in_px[i*DATA_W +: DATA_W]; centre tap is i = N_TAPS/2.
- in_mode  in  2  0 = median, 1 = min, 2 = max, 3 = adaptive. Sampled with the window.
- in_last  in  1  end-of-line marker, carried with the window.
- out_valid  out  1  out_px is valid.
- out_ready  in  1  downstream accepts out_px.
- out_px  out  DATA_W  filtered pixel.
- out_last  out  1  in_last of the same window.

Behaviour:
- Pipeline: stage 0 is the capture register. Stages 1..N_TAPS are each one registered compare-exchange pass.
  - Odd-numbered stages compare pairs (0,1), (2,3), …
  - Even-numbered stages compare pairs (1,2), (3,4), …
  - Each exchange places the smaller value at the lower index. Ties do not swap.
  - N_TAPS passes fully sort any input.
- Each stage carries: valid bit, sorted array, mode, original centre pixel, last flag.
- Output mux, registered in the final stage:
  - min = sorted[0].
  - max = sorted[N_TAPS-1].
  - median = sorted[N_TAPS/2].
  - adaptive = median if the centre pixel is 0 or 2^DATA_W-1, otherwise the centre pixel unchanged.
- Latency: N_TAPS+1 cycles from an accepted input (in_valid && in_ready) to out_valid, with no stalls. Throughput is one window per cycle.
- Stall is global:
  - adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv = 0, every stage register holds its value. out_px and out_last stay stable while out_valid = 1 and out_ready = 0.
- Bubbles: in_valid = 0 while adv = 1 injects an invalid slot. Data in invalid slots is don't-care but must not produce out_valid.
- in_mode and in_last are sampled only on acceptance and never affect windows already in flight.
- Reset (rst = 0 at a clock edge):
  - All valid bits clear; out_valid = 0, out_px = 0, out_last = 0.
  - in_ready = 1 in the first cycle after rst returns high.
  - Reset mid-stream discards all in-flight windows with no partial output.
  - Reset wins over a simultaneous handshake.
- Arithmetic: comparisons are unsigned DATA_W. There is no arithmetic widening.

Decomposition:
- Package rank_filter_pkg holds:
  - typedef filt_mode_e with MODE_MEDIAN, MODE_MIN, MODE_MAX, MODE_ADAPTIVE.
  - The stage-payload struct, parametrised through localparams in the instantiating module.
  - Function is_impulse(pixel, width).
- Sub-module oe_sort_stage, parameters DATA_W, N_TAPS, ODD_PHASE:
  - One registered compare-exchange pass with enable and synchronous active-low reset.
  - It is instantiated N_TAPS times by a generate loop.
- The top level holds the capture stage, the output mux and the handshake.

Test Plan:
- N_TAPS=9, DATA_W=8, median, window {9,3,7,1,5,8,2,6,4}, out_ready=1 → out_px=5, out_valid exactly 10 cycles after acceptance.
- Same window in min, then max, then a window of all 200 in median, back-to-back → outputs 1, 9, 200 on three consecutive cycles.
- Adaptive with centre=255, window {10,20,30,40,255,50,60,70,80} → out_px=50. Adaptive with centre=120 in that window → out_px=120. Adaptive with centre=0 → median.
- 20 back-to-back random windows with in_last on the 20th; out_ready low for cycles 5–7 of output → in_ready=0 during the stall, out_px stable, all 20 results in order versus the reference model, out_last only on result 20.
- rst low for 1 cycle while 5 windows are in flight → out_valid=0 and out_px=0 next cycle, none of the 5 ever emitted, new window accepted the following cycle.
- N_TAPS=25, DATA_W=10, random windows including duplicates and extremes 0/1023 → median matches the model, latency 26 cycles.
